// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared types and helpers for the mux_rr_n slice.
//   - sel_mode_t : explicit-select vs. round-robin arbitration mode
//   - rr_next()  : rotating priority search, returns {found, idx}
//   The helper works on a fixed maximum width (RR_MAX_N channels); callers
//   zero-extend their pointer/valid vectors and pass the live channel count.
// -----------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic {
        SEL_EXPLICIT = 1'b0,
        SEL_RR       = 1'b1
    } sel_mode_t;

    localparam int RR_MAX_N = 32;
    localparam int RR_IDX_W = 5;

    // Search valid[] starting at ptr+1, wrapping at n-1 -> 0 (n need not be a
    // power of two). ptr must be < n. Result is {found, idx}.
    function automatic logic [RR_IDX_W:0] rr_next(
        input logic [RR_IDX_W-1:0] ptr,
        input logic [RR_MAX_N-1:0] valid,
        input int                  n
    );
        logic                found;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W-1:0] cand_idx;
        int                  cand;
        found = 1'b0;
        idx   = {RR_IDX_W{1'b0}};
        for (int k = 1; k <= RR_MAX_N; k++) begin
            if (k <= n) begin
                // ptr < n and k <= n, so one subtraction brings cand below n
                cand = int'(ptr) + k;
                if (cand >= n) begin
                    cand = cand - n;
                end
                cand_idx = RR_IDX_W'(cand);
                if (!found && valid[cand_idx]) begin
                    found = 1'b1;
                    idx   = cand_idx;
                end
            end
        end
        return {found, idx};
    endfunction

endpackage : mux_pkg

// File: rtl/mux_rr_n_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
//   Combinational round-robin search: finds the first set bit of valid,
//   starting at ptr+1 and wrapping modulo N.
//   Parameters: N (channels, 2..32), SEL_W (derived index width)
//   Ports:
//     ptr    in   SEL_W  index of the most recent grant
//     valid  in   N      per-channel request
//     found  out  1      at least one request present
//     idx    out  SEL_W  winning channel (0 when !found)
// -----------------------------------------------------------------------------
module rr_arb
    import mux_pkg::*;
#(
    parameter int N     = 3,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [SEL_W-1:0] ptr,
    input  logic [N-1:0]     valid,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [RR_IDX_W:0] res_s;
    logic              unused_s;

    // Rotating priority search on zero-extended operands
    always_comb begin
        res_s = rr_next(RR_IDX_W'(ptr), RR_MAX_N'(valid), N);
    end

    assign found    = res_s[RR_IDX_W];
    assign idx      = res_s[SEL_W-1:0];
    // upper index bits are always zero for N <= 2**SEL_W
    assign unused_s = ^res_s;

endmodule : rr_arb

// File: rtl/mux_rr_n.sv
// -----------------------------------------------------------------------------
// mux_rr_n
//   N-channel, WIDTH-bit registered mux with valid/ready on every input and on
//   the output. Winner is chosen either by an explicit select or by
//   round-robin arbitration. One output register stage, latency 1 cycle,
//   full throughput (simultaneous drain and reload).
//   Optional feature macro: MUX_RR_ERR_EN adds the sticky err_sel flag that
//   records an out-of-range explicit select while any input was valid.
//   Ports:
//     clk        in   1        rising-edge clock
//     reset_n    in   1        asynchronous active-low reset
//     in_valid   in   N        per-channel valid
//     in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//     in_ready   out  N        per-channel ready (one-hot or zero), combinational
//     sel_mode   in   1        0 = explicit, 1 = round-robin
//     sel        in   SEL_W    channel index for explicit mode
//     out_valid  out  1        output register holds valid data
//     out_data   out  WIDTH    registered data
//     out_ready  in   1        consumer accepts out_data this cycle
//     grant_idx  out  SEL_W    channel that produced out_data
//     err_sel    out  1        (MUX_RR_ERR_EN only) sticky bad-select flag
// -----------------------------------------------------------------------------
module mux_rr_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic               sel_mode,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   grant_idx
`ifdef MUX_RR_ERR_EN
    ,
    output logic               err_sel
`endif
);

    localparam logic [SEL_W:0]   N_L       = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] PTR_RESET = SEL_W'(N - 1);

    sel_mode_t          mode_s;
    logic               sel_ok_s;
    logic               rr_found_s;
    logic [SEL_W-1:0]   rr_idx_s;
    logic               win_found_s;
    logic [SEL_W-1:0]   win_idx_s;
    logic               accept_s;
    logic               transfer_s;
    logic [N-1:0]       in_ready_s;

    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [SEL_W-1:0]   grant_idx_r;
    logic [SEL_W-1:0]   rr_ptr_r;

    assign mode_s   = sel_mode_t'(sel_mode);
    assign sel_ok_s = ({1'b0, sel} < N_L);
    assign accept_s = !out_valid_r || out_ready;

    rr_arb #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arb (
        .ptr   (rr_ptr_r),
        .valid (in_valid),
        .found (rr_found_s),
        .idx   (rr_idx_s)
    );

    // Winner selection for the active mode
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {SEL_W{1'b0}};
        case (mode_s)
            SEL_RR: begin
                win_found_s = rr_found_s;
                win_idx_s   = rr_idx_s;
            end
            SEL_EXPLICIT: begin
                if (sel_ok_s) begin
                    win_found_s = in_valid[sel];
                    win_idx_s   = sel;
                end else begin
                    win_found_s = 1'b0;
                    win_idx_s   = {SEL_W{1'b0}};
                end
            end
            default: begin
                win_found_s = 1'b0;
                win_idx_s   = {SEL_W{1'b0}};
            end
        endcase
    end

    // A winner always has in_valid set, so a transfer is just found & accept.
    // reset_n gates the handshake so in_ready drops with reset, not a clock edge.
    assign transfer_s = win_found_s && accept_s && reset_n;

    // One-hot ready toward the winning channel
    always_comb begin
        in_ready_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (transfer_s && (win_idx_s == SEL_W'(i))) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign in_ready = in_ready_s;

    // Output register, grant index and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            grant_idx_r <= {SEL_W{1'b0}};
            rr_ptr_r    <= PTR_RESET;
        end else if (transfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[win_idx_s*WIDTH +: WIDTH];
            grant_idx_r <= win_idx_s;
            // tracked in both modes so RR fairness resumes after a mode switch
            rr_ptr_r    <= win_idx_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign grant_idx = grant_idx_r;

`ifdef MUX_RR_ERR_EN
    logic bad_sel_s;
    logic err_sel_r;

    assign bad_sel_s = (mode_s == SEL_EXPLICIT) && !sel_ok_s && (|in_valid);

    // Sticky out-of-range select flag, cleared only by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sel_r <= 1'b0;
        end else if (bad_sel_s) begin
            err_sel_r <= 1'b1;
        end else begin
            err_sel_r <= err_sel_r;
        end
    end

    assign err_sel = err_sel_r;
`endif

endmodule : mux_rr_n
